// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, transmitter state encoding and
// the parity-bit helper used when a frame reaches its parity slot.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5,
    BREAK  = 3'd6
  } tx_state_t;

  // acc is the XOR of all data bits of the frame
  function automatic logic parity_bit(input logic [1:0] mode, input logic acc);
    case (mode)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and full/empty flags; shared by the
// UART transmitter and receiver. Read data is the registered head entry.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // storage array; contents need no reset because the pointers guard them
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words are framed with optional
// parity and one or two stop bits, with break generation, advancing on baud ticks.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_baud_tick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          send_break,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_pin
);

  localparam int                CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_t            state_r, state_s;
  logic                 pin_r, pin_s;
  logic                 busy_r;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic                 par_r, par_s;
  logic [1:0]           mode_r, mode_s;
  logic                 two_r, two_s;
  logic                 launch_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [DATA_BITS-1:0] fifo_rdata_s;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (pop_s),
    .wdata (tx_data),
    .rdata (fifo_rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  assign tx_ready = ~full_s;
  assign tx_pin   = pin_r;
  assign tx_busy  = busy_r;

  // next-state and next-pin logic; the closing stop tick acts as the idle tick
  // so back-to-back frames are separated by exactly the stop-bit mark
  always_comb begin
    state_s   = state_r;
    pin_s     = pin_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    par_s     = par_r;
    mode_s    = mode_r;
    two_s     = two_r;
    launch_s  = 1'b0;
    pop_s     = 1'b0;

    if (tx_baud_tick) begin
      case (state_r)
        IDLE: launch_s = 1'b1;
        START: begin
          pin_s     = shift_r[0];
          shift_s   = shift_r >> 1;
          par_s     = par_r ^ shift_r[0];
          bit_cnt_s = {CNT_W{1'b0}};
          state_s   = DATA;
        end
        DATA: begin
          if (bit_cnt_r == LAST_BIT) begin
            if (mode_r == PAR_NONE) begin
              pin_s   = 1'b1;
              state_s = STOP1;
            end else begin
              pin_s   = parity_bit(mode_r, par_r);
              state_s = PARITY;
            end
          end else begin
            pin_s     = shift_r[0];
            shift_s   = shift_r >> 1;
            par_s     = par_r ^ shift_r[0];
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
        PARITY: begin
          pin_s   = 1'b1;
          state_s = STOP1;
        end
        STOP1: begin
          if (two_r) begin
            pin_s   = 1'b1;
            state_s = STOP2;
          end else begin
            launch_s = 1'b1;
          end
        end
        STOP2: launch_s = 1'b1;
        BREAK: begin
          if (send_break) begin
            pin_s = 1'b0;
          end else begin
            pin_s   = 1'b1;
            two_s   = 1'b0;
            state_s = STOP1;
          end
        end
        default: begin
          pin_s   = 1'b1;
          state_s = IDLE;
        end
      endcase
    end else begin
      if (!(state_r inside {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK})) begin
        pin_s   = 1'b1;
        state_s = IDLE;
      end else begin
        state_s = state_r;
      end
    end

    if (launch_s) begin
      if (send_break) begin
        pin_s   = 1'b0;
        state_s = BREAK;
      end else if (!empty_s) begin
        pop_s   = 1'b1;
        shift_s = fifo_rdata_s;
        par_s   = 1'b0;
        mode_s  = parity_mode;
        two_s   = two_stop;
        pin_s   = 1'b0;
        state_s = START;
      end else begin
        pin_s   = 1'b1;
        state_s = IDLE;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // frame state, serial pin and busy flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pin_r     <= 1'b1;
      busy_r    <= 1'b0;
      shift_r   <= {DATA_BITS{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      par_r     <= 1'b0;
      mode_r    <= PAR_NONE;
      two_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      pin_r     <= pin_s;
      busy_r    <= (state_s != IDLE);
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      par_r     <= par_s;
      mode_r    <= mode_s;
      two_r     <= two_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: the expected serial line is built as a
// queue of per-tick levels from the framing rules and compared on every tick.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       valid8 = 1'b0;
  logic       valid7 = 1'b0;
  logic [7:0] data8 = 8'h00;
  logic [6:0] data7 = 7'h00;
  logic [1:0] pmode = 2'b00;
  logic       two_stop = 1'b0;
  logic       send_break = 1'b0;
  logic       ready8, busy8, pin8;
  logic       ready7, busy7, pin7;
  logic [2:0] count8, count7;

  int   total_cnt = 0;
  int   pass_cnt  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_baud_tick(tick), .tx_data(data8), .tx_valid(valid8),
    .tx_ready(ready8), .parity_mode(pmode), .two_stop(two_stop), .send_break(send_break),
    .tx_busy(busy8), .fifo_count(count8), .tx_pin(pin8)
  );

  uart_tx_cfg #(.DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(rst), .tx_baud_tick(tick), .tx_data(data7), .tx_valid(valid7),
    .tx_ready(ready7), .parity_mode(pmode), .two_stop(two_stop), .send_break(send_break),
    .tx_busy(busy7), .fifo_count(count7), .tx_pin(pin7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic tk);
    @(negedge clk); tick = tk;
    @(posedge clk); #1; tick = 1'b0;
  endtask

  task automatic push8(input logic [7:0] d);
    @(negedge clk); data8 = d; valid8 = 1'b1;
    @(posedge clk); #1; valid8 = 1'b0;
  endtask

  task automatic push7(input logic [6:0] d);
    @(negedge clk); data7 = d; valid7 = 1'b1;
    @(posedge clk); #1; valid7 = 1'b0;
  endtask

  // reference frame: start 0, data LSB first, optional parity, stop marks
  task automatic add_frame(input int nb, input logic [8:0] d, input logic [1:0] pm, input logic ts);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == 2'd1) exp_q.push_back(p);
    else if (pm == 2'd2) exp_q.push_back(~p);
    else if (pm == 2'd3) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    if (ts) exp_q.push_back(1'b1);
  endtask

  task automatic run_ticks(input int n, input logic sel, input string tag);
    for (int i = 0; i < n; i++) begin
      logic e;
      repeat ($urandom_range(0, 2)) step(1'b0);
      step(1'b1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      check(tag, sel ? pin7 : pin8, e);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_pin", pin8, 1);
    check("reset_ready", ready8, 1);
    check("reset_busy", busy8, 0);
    check("reset_count", count8, 0);
    @(negedge clk); rst = 1'b0;

    // 8E1 0xA5, pushed on a tick cycle: that tick must not pop it
    pmode = 2'd1; two_stop = 1'b0;
    @(negedge clk); data8 = 8'hA5; valid8 = 1'b1; tick = 1'b1;
    @(posedge clk); #1; valid8 = 1'b0; tick = 1'b0;
    check("push_tick_no_pop", pin8, 1);
    check("push_tick_count", count8, 1);
    add_frame(8, 9'h0A5, 2'd1, 1'b0);
    run_ticks(11, 1'b0, "frame_a5_8e1");
    check("busy_in_stop", busy8, 1);
    run_ticks(1, 1'b0, "idle_after_a5");
    check("busy_fall", busy8, 0);

    // 7O2 0x41 on the 7-bit instance
    pmode = 2'd2; two_stop = 1'b1;
    push7(7'h41);
    add_frame(7, 9'h041, 2'd2, 1'b1);
    run_ticks(12, 1'b1, "frame_41_7o2");
    check("busy7_fall", busy7, 0);

    // fill the FIFO with no ticks; the 5th word must be refused
    pmode = 2'd0; two_stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); data8 = 8'h10 + 8'(i); valid8 = 1'b1;
      @(posedge clk); #1;
      check("fill_count", count8, (i < 4) ? i + 1 : 4);
      check("fill_ready", ready8, (i >= 3) ? 0 : 1);
    end
    valid8 = 1'b0;
    for (int i = 0; i < 4; i++) add_frame(8, 9'h010 + 9'(i), 2'd0, 1'b0);
    run_ticks(41, 1'b0, "drain4");
    check("drain_busy", busy8, 0);
    check("drain_count", count8, 0);

    // parity switched on mid-frame only affects the next frame
    push8(8'h96);
    push8(8'h3B);
    add_frame(8, 9'h096, 2'd0, 1'b0);
    run_ticks(4, 1'b0, "cfg_first");
    pmode = 2'd1;
    add_frame(8, 9'h03B, 2'd1, 1'b0);
    run_ticks(18, 1'b0, "cfg_second");
    check("cfg_busy", busy8, 0);

    // break requested mid-frame with 0x55 queued
    pmode = 2'd0; two_stop = 1'b0;
    push8(8'h0F);
    push8(8'h55);
    add_frame(8, 9'h00F, 2'd0, 1'b0);
    run_ticks(3, 1'b0, "brk_frame_head");
    send_break = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
    run_ticks(10, 1'b0, "brk_frame_tail_low");
    check("brk_busy", busy8, 1);
    check("brk_count_held", count8, 1);
    send_break = 1'b0;
    exp_q.push_back(1'b1);
    add_frame(8, 9'h055, 2'd0, 1'b0);
    run_ticks(12, 1'b0, "brk_release_55");
    check("brk_end_busy", busy8, 0);
    check("brk_end_count", count8, 0);

    // asynchronous reset during data bit 3
    push8(8'h00);
    push8(8'hAB);
    add_frame(8, 9'h000, 2'd0, 1'b0);
    run_ticks(5, 1'b0, "pre_reset");
    check("pre_reset_count", count8, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_pin", pin8, 1);
    check("rst_ready", ready8, 1);
    check("rst_count", count8, 0);
    check("rst_busy", busy8, 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    push8(8'h3C);
    add_frame(8, 9'h03C, 2'd0, 1'b0);
    run_ticks(11, 1'b0, "after_reset_3c");
    check("after_reset_busy", busy8, 0);

    // random words and configurations
    for (int it = 0; it < 8; it++) begin
      logic [1:0] pm;
      logic       ts;
      int         nw;
      int         len;
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      pmode = pm; two_stop = ts; len = 0;
      for (int j = 0; j < nw; j++) begin
        logic [7:0] d;
        d = 8'($urandom);
        push8(d);
        add_frame(8, {1'b0, d}, pm, ts);
        len += 1 + 8 + int'(pm != 2'd0) + (ts ? 2 : 1);
      end
      run_ticks(len + 1, 1'b0, "rand_frames");
      check("rand_idle", busy8, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter with an integrated transmit FIFO. It is the next generation of the team's fixed 8N1 transmitter. It sits between the system-side byte producer (valid/ready) and the serial pin, driven by the shared baud-tick generator. New capabilities:
- parameterised data width and FIFO depth
- runtime-selectable parity and stop-bit count
- break generation
- push acceptance on any clock cycle, not only on baud ticks

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9.
- FIFO_DEPTH, 4: transmit FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_baud_tick  in  1  one-clk pulse per bit period.
- tx_data  in  DATA_BITS  word to send, LSB first.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  FIFO can accept; push = tx_valid & tx_ready.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1).
- two_stop  in  1  1 = two stop bits, 0 = one.
- send_break  in  1  level request to hold the line low.
- tx_busy  out  1  frame or break in progress.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_pin  out  1  serial output, idle high.

## Operation
- Reset values: tx_pin=1, tx_ready=1, tx_busy=0, fifo_count=0, FSM=IDLE, FIFO pointers=0.
- **FIFO**
  - A push happens on any clk edge where tx_valid & tx_ready.
  - tx_ready = !full, from registered occupancy.
  - No bypass: a word pushed in cycle N is poppable from cycle N+1.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- **FSM advance**
  - The FSM moves only on clk edges with tx_baud_tick=1.
  - tx_pin is registered and changes on that edge.
- **IDLE**
  - tx_pin=1.
  - On tick, if send_break=1: go to BREAK. Break has priority over queued data.
  - Else, if the FIFO is non-empty: pop into the shift register, latch parity_mode and two_stop, drive tx_pin=0, go to START.
  - Config inputs are sampled only at this point. Changes mid-frame have no effect until the next frame.
- **START**
  - On tick: tx_pin=shift[0], shift right, bit_cnt=0, go to DATA.
- **DATA**
  - On tick, while bit_cnt < DATA_BITS-1: tx_pin=shift[0], shift right, bit_cnt++.
  - On the last bit: if parity is enabled, tx_pin=parity and go to PARITY. Otherwise tx_pin=1 and go to STOP1.
  - Parity is accumulated during the shift, over DATA_BITS bits.
  - Even parity = XOR of the data. Odd parity = its complement.
- **PARITY**
  - On tick: tx_pin=1, go to STOP1.
- **STOP1**
  - On tick: if two_stop is latched, go to STOP2 (tx_pin stays 1). Else go to IDLE.
- **STOP2**
  - On tick: go to IDLE.
- **BREAK**
  - tx_pin=0 while send_break=1, evaluated on each tick.
  - On the first tick with send_break=0: tx_pin=1, go to STOP1 with one stop bit, giving a guaranteed mark of at least one bit time.
- tx_busy = (state != IDLE).
- Unused or illegal state encodings go to IDLE with tx_pin=1.

## Timing
- Frame length in ticks = 1 + DATA_BITS + (parity?1:0) + (two_stop?2:1). Each level is held for exactly one tick interval.
- Pop-to-start latency:
  - The start bit appears at the first tick edge after the word is poppable.
  - Back-to-back frames have no idle gap. The IDLE tick that pops the next word occurs one tick after the last stop bit begins.
  - Result: an exact stop-bit-length mark between frames.
- Reset mid-frame:
  - tx_pin goes to 1 immediately (asynchronous).
  - The FIFO is cleared and the in-flight frame is abandoned.
- Reset release: the first frame may start on the first tick after release.
- A tick arriving on a cycle when a push empties→non-empty does not pop that word.

## Structure
Shared package uart_pkg holds:
- parity-mode localparams: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK
- the tx state encoding: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK

Sub-module uart_sync_fifo (parameters WIDTH, DEPTH): single-clock FIFO with count output, full/empty flags, async rst. It is reusable by the receiver. The FSM, shift register, parity accumulator and bit counter live in uart_tx_cfg.

## Test plan
- DATA_BITS=8, parity even, one stop, push 0xA5:
  - tx_pin per tick: 0,1,0,1,0,0,1,0,1,0,1 (11 ticks).
  - tx_busy falls after the stop bit.
- DATA_BITS=7, parity odd, two_stop=1, push 0x41:
  - tx_pin per tick: 0,1,0,0,0,0,0,1,1,1,1 (11 ticks).
- FIFO_DEPTH=4, no ticks, push 5 words back-to-back:
  - tx_ready=0 after the 4th push and fifo_count=4.
  - The 5th word is held by the producer.
  - Enabling ticks then drains 4 contiguous frames with no gap beyond the stop bit.
- Config change mid-frame:
  - Switch parity none→even during DATA of the 1st frame.
  - The 1st frame has no parity bit; the 2nd frame has one.
- send_break=1 while a frame is active and the FIFO holds 0x55:
  - The current frame completes.
  - Then tx_pin=0 for every tick while asserted.
  - After deassert: one tick of 1, then the 0x55 frame.
- Assert rst during DATA bit 3:
  - tx_pin=1, tx_ready=1, fifo_count=0 in the same cycle.
  - A subsequent push of 0x3C transmits correctly.
